// File: rtl/alu_rs_if.sv
// Issue, common-data-bus and dispatch signals of the ALU reservation station.
// The master modport belongs to the issue/CDB side. The slave modport belongs to the station.
interface alu_rs_if #(
    parameter int TAG_W = 3
);
    logic             flush;
    logic             issue_valid;
    logic [4:0]       issue_op;
    logic [TAG_W-1:0] issue_des;
    logic [31:0]      issue_v1;
    logic [31:0]      issue_v2;
    logic [TAG_W-1:0] issue_q1;
    logic [TAG_W-1:0] issue_q2;
    logic             full;
    logic [TAG_W-1:0] cdb_alu_tag;
    logic [31:0]      cdb_alu_value;
    logic [TAG_W-1:0] cdb_lsb_tag;
    logic [31:0]      cdb_lsb_value;
    logic [31:0]      alu_value_1;
    logic [31:0]      alu_value_2;
    logic [4:0]       alu_op;
    logic [TAG_W-1:0] alu_des;

    modport master (
        output flush, issue_valid, issue_op, issue_des, issue_v1, issue_v2, issue_q1, issue_q2,
        output cdb_alu_tag, cdb_alu_value, cdb_lsb_tag, cdb_lsb_value,
        input  full, alu_value_1, alu_value_2, alu_op, alu_des
    );

    modport slave (
        input  flush, issue_valid, issue_op, issue_des, issue_v1, issue_v2, issue_q1, issue_q2,
        input  cdb_alu_tag, cdb_alu_value, cdb_lsb_tag, cdb_lsb_value,
        output full, alu_value_1, alu_value_2, alu_op, alu_des
    );
endinterface

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU.
// It holds issued micro-ops until both operands are known.
// It snoops the ALU and load/store broadcasts to capture operand values.
// Each cycle it dispatches the lowest-index ready entry. Tag 0 means "none".
module alu_rs #(
    parameter int ENTRIES = 4,
    parameter int TAG_W   = 3
) (
    input logic     clk,
    input logic     rst,
    alu_rs_if.slave bus
);
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0] busy;
    logic [4:0]         op_q  [ENTRIES];
    logic [TAG_W-1:0]   des_q [ENTRIES];
    logic [31:0]        v1_q  [ENTRIES];
    logic [31:0]        v2_q  [ENTRIES];
    logic [TAG_W-1:0]   q1_q  [ENTRIES];
    logic [TAG_W-1:0]   q2_q  [ENTRIES];

    logic [31:0]        out_v1;
    logic [31:0]        out_v2;
    logic [4:0]         out_op;
    logic [TAG_W-1:0]   out_des;

    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               rdy_found;
    logic [IDX_W-1:0]   rdy_idx;

    logic [TAG_W-1:0]   alu_tag;
    logic [31:0]        alu_val;
    logic [TAG_W-1:0]   lsb_tag;
    logic [31:0]        lsb_val;

    assign alu_tag = bus.cdb_alu_tag;
    assign alu_val = bus.cdb_alu_value;
    assign lsb_tag = bus.cdb_lsb_tag;
    assign lsb_val = bus.cdb_lsb_value;

    assign bus.full        = &busy;
    assign bus.alu_value_1 = out_v1;
    assign bus.alu_value_2 = out_v2;
    assign bus.alu_op      = out_op;
    assign bus.alu_des     = out_des;

    // Returns the operand {tag, value} after this cycle's broadcasts.
    // The ALU port wins if both ports carry the same tag.
    function automatic logic [TAG_W+31:0] snoop(
        input logic [TAG_W-1:0] q,
        input logic [31:0]      v,
        input logic [TAG_W-1:0] at,
        input logic [31:0]      av,
        input logic [TAG_W-1:0] lt,
        input logic [31:0]      lv
    );
        if (q != '0 && q == at) return {{TAG_W{1'b0}}, av};
        if (q != '0 && q == lt) return {{TAG_W{1'b0}}, lv};
        return {q, v};
    endfunction

    // Find the lowest-index free slot and the lowest-index ready slot.
    // Both searches use the pre-edge state.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        rdy_found  = 1'b0;
        rdy_idx    = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!busy[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (busy[i] && q1_q[i] == '0 && q2_q[i] == '0 && !rdy_found) begin
                rdy_found = 1'b1;
                rdy_idx   = IDX_W'(i);
            end
        end
    end

    // Per-edge update, in priority order: reset, flush, then normal operation.
    // Normal operation does dispatch, wakeup and issue.
    // Dispatch and issue never touch the same slot: issue only targets a slot that was free before the edge.
    always_ff @(posedge clk) begin
        if (!rst || bus.flush) begin
            busy    <= '0;
            out_v1  <= '0;
            out_v2  <= '0;
            out_op  <= '0;
            out_des <= '0;
        end else begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (busy[i]) begin
                    {q1_q[i], v1_q[i]} <= snoop(q1_q[i], v1_q[i], alu_tag, alu_val, lsb_tag, lsb_val);
                    {q2_q[i], v2_q[i]} <= snoop(q2_q[i], v2_q[i], alu_tag, alu_val, lsb_tag, lsb_val);
                end
            end
            if (rdy_found) begin
                out_v1        <= v1_q[rdy_idx];
                out_v2        <= v2_q[rdy_idx];
                out_op        <= op_q[rdy_idx];
                out_des       <= des_q[rdy_idx];
                busy[rdy_idx] <= 1'b0;
            end else begin
                out_v1  <= '0;
                out_v2  <= '0;
                out_op  <= '0;
                out_des <= '0;
            end
            if (bus.issue_valid && free_found) begin
                busy[free_idx]  <= 1'b1;
                op_q[free_idx]  <= bus.issue_op;
                des_q[free_idx] <= bus.issue_des;
                {q1_q[free_idx], v1_q[free_idx]} <=
                    snoop(bus.issue_q1, bus.issue_v1, alu_tag, alu_val, lsb_tag, lsb_val);
                {q2_q[free_idx], v2_q[free_idx]} <=
                    snoop(bus.issue_q2, bus.issue_v2, alu_tag, alu_val, lsb_tag, lsb_val);
            end
        end
    end
endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs.
// It runs directed scenarios and then random traffic against a slot-array reference model.
module tb_alu_rs;
    localparam int N  = 4;
    localparam int TW = 3;

    logic clk = 1'b0;
    logic rst;

    alu_rs_if #(.TAG_W(TW)) bus();

    alu_rs #(.ENTRIES(N), .TAG_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          busy;
        bit [4:0]    op;
        bit [TW-1:0] des;
        bit [31:0]   v1;
        bit [31:0]   v2;
        bit [TW-1:0] q1;
        bit [TW-1:0] q2;
    } ent_t;

    ent_t        m [N];
    bit [31:0]   e_v1  = '0;
    bit [31:0]   e_v2  = '0;
    bit [4:0]    e_op  = '0;
    bit [TW-1:0] e_des = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_full();
        foreach (m[i]) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    // An operand waiting on tag q picks up a broadcast carrying q. The ALU port is consulted first.
    function automatic bit [TW+31:0] resolve(bit [TW-1:0] q, bit [31:0] v);
        if (q != 0 && q == bus.cdb_alu_tag) return {TW'(0), bus.cdb_alu_value};
        if (q != 0 && q == bus.cdb_lsb_tag) return {TW'(0), bus.cdb_lsb_value};
        return {q, v};
    endfunction

    task automatic model_step();
        int sel = -1;
        int fr  = -1;
        bit was_full;
        if (!rst || bus.flush) begin
            foreach (m[i]) m[i].busy = 1'b0;
            e_v1 = 0; e_v2 = 0; e_op = 0; e_des = 0;
            return;
        end
        was_full = model_full();
        foreach (m[i]) begin
            if (sel < 0 && m[i].busy && m[i].q1 == 0 && m[i].q2 == 0) sel = i;
            if (fr < 0 && !m[i].busy) fr = i;
        end
        if (sel >= 0) begin
            e_v1 = m[sel].v1; e_v2 = m[sel].v2; e_op = m[sel].op; e_des = m[sel].des;
            m[sel].busy = 1'b0;
        end else begin
            e_v1 = 0; e_v2 = 0; e_op = 0; e_des = 0;
        end
        foreach (m[i]) begin
            if (m[i].busy) begin
                {m[i].q1, m[i].v1} = resolve(m[i].q1, m[i].v1);
                {m[i].q2, m[i].v2} = resolve(m[i].q2, m[i].v2);
            end
        end
        if (bus.issue_valid && !was_full) begin
            m[fr].busy = 1'b1;
            m[fr].op   = bus.issue_op;
            m[fr].des  = bus.issue_des;
            {m[fr].q1, m[fr].v1} = resolve(bus.issue_q1, bus.issue_v1);
            {m[fr].q2, m[fr].v2} = resolve(bus.issue_q2, bus.issue_v2);
        end
    endtask

    task automatic compare_all();
        check("alu_des", 32'(bus.alu_des), 32'(e_des));
        check("alu_value_1", bus.alu_value_1, e_v1);
        check("alu_value_2", bus.alu_value_2, e_v2);
        check("alu_op", 32'(bus.alu_op), 32'(e_op));
        check("full", 32'(bus.full), 32'(model_full()));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        bus.flush         = 1'b0;
        bus.issue_valid   = 1'b0;
        bus.issue_op      = '0;
        bus.issue_des     = '0;
        bus.issue_v1      = '0;
        bus.issue_v2      = '0;
        bus.issue_q1      = '0;
        bus.issue_q2      = '0;
        bus.cdb_alu_tag   = '0;
        bus.cdb_alu_value = '0;
        bus.cdb_lsb_tag   = '0;
        bus.cdb_lsb_value = '0;
    endtask

    task automatic issue(input bit [4:0] op, input bit [TW-1:0] des,
                         input bit [31:0] v1, input bit [TW-1:0] q1,
                         input bit [31:0] v2, input bit [TW-1:0] q2);
        bus.issue_valid = 1'b1;
        bus.issue_op    = op;
        bus.issue_des   = des;
        bus.issue_v1    = v1;
        bus.issue_q1    = q1;
        bus.issue_v2    = v2;
        bus.issue_q2    = q2;
    endtask

    // Stimulus: directed scenarios first, then random traffic.
    initial begin
        idle();
        rst = 1'b0;

        // Reset held for two cycles while an issue is requested.
        issue(5'd1, 3'd1, 32'd1, 3'd0, 32'd2, 3'd0);
        step();
        step();
        check("rst_des", 32'(bus.alu_des), 32'd0);
        check("rst_full", 32'(bus.full), 32'd0);
        idle();
        rst = 1'b1;
        step();
        step();
        check("post_rst_des", 32'(bus.alu_des), 32'd0);

        // A ready issue dispatches on the following edge.
        issue(5'd0, 3'd3, 32'd7, 3'd0, 32'd5, 3'd0);
        step();
        check("ready_early", 32'(bus.alu_des), 32'd0);
        idle();
        step();
        check("ready_des", 32'(bus.alu_des), 32'd3);
        check("ready_v1", bus.alu_value_1, 32'd7);
        check("ready_v2", bus.alu_value_2, 32'd5);
        step();
        check("ready_idle", 32'(bus.alu_des), 32'd0);

        // Wakeup from the load/store port. An unrelated tag does nothing.
        issue(5'd2, 3'd4, 32'hDEAD, 3'd2, 32'd10, 3'd0);
        step();
        idle();
        bus.cdb_lsb_tag = 3'd5; bus.cdb_lsb_value = 32'h55;
        step();
        idle();
        step();
        check("wake_unrel", 32'(bus.alu_des), 32'd0);
        bus.cdb_lsb_tag = 3'd2; bus.cdb_lsb_value = 32'h100;
        step();
        idle();
        step();
        check("wake_des", 32'(bus.alu_des), 32'd4);
        check("wake_v1", bus.alu_value_1, 32'h100);
        check("wake_v2", bus.alu_value_2, 32'd10);

        // Forwarding at issue time from the ALU port.
        issue(5'd3, 3'd5, 32'd1, 3'd0, 32'd0, 3'd6);
        bus.cdb_alu_tag = 3'd6; bus.cdb_alu_value = 32'hFFFF_FFFF;
        step();
        idle();
        step();
        check("fwd_des", 32'(bus.alu_des), 32'd5);
        check("fwd_v2", bus.alu_value_2, 32'hFFFF_FFFF);
        step();

        // Fill every slot, drop the extra issue, then drain in index order.
        for (int i = 1; i <= N; i++) begin
            issue(5'(i), TW'(i), 32'd0, 3'd7, 32'(i * 3), 3'd0);
            step();
        end
        check("full_set", 32'(bus.full), 32'd1);
        issue(5'd9, 3'd5, 32'd0, 3'd7, 32'd0, 3'd0);
        step();
        check("full_drop", 32'(bus.full), 32'd1);
        idle();
        bus.cdb_alu_tag = 3'd7; bus.cdb_alu_value = 32'h77;
        step();
        idle();
        step();
        check("drain0_des", 32'(bus.alu_des), 32'd1);
        check("drain0_full", 32'(bus.full), 32'd0);
        check("drain0_v1", bus.alu_value_1, 32'h77);
        for (int i = 2; i <= N; i++) begin
            step();
            check("drain_des", 32'(bus.alu_des), 32'(i));
        end
        step();
        check("drain_none", 32'(bus.alu_des), 32'd0);

        // Flush discards pending entries and a ready entry.
        for (int i = 1; i <= 3; i++) begin
            issue(5'd4, TW'(i), 32'd0, 3'd3, 32'd0, 3'd0);
            step();
        end
        issue(5'd6, 3'd4, 32'd8, 3'd0, 32'd9, 3'd0);
        step();
        idle();
        bus.flush = 1'b1;
        step();
        check("flush_des", 32'(bus.alu_des), 32'd0);
        check("flush_full", 32'(bus.full), 32'd0);
        idle();
        bus.cdb_alu_tag = 3'd3; bus.cdb_alu_value = 32'h33;
        step();
        idle();
        step();
        check("flush_stale", 32'(bus.alu_des), 32'd0);

        // Random traffic compared against the model every cycle.
        for (int c = 0; c < 2000; c++) begin
            idle();
            rst       = ($urandom_range(0, 199) != 0);
            bus.flush = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) < 6)
                issue(5'($urandom), TW'($urandom_range(1, 7)),
                      $urandom, ($urandom_range(0, 1) != 0) ? TW'($urandom_range(1, 7)) : TW'(0),
                      $urandom, ($urandom_range(0, 1) != 0) ? TW'($urandom_range(1, 7)) : TW'(0));
            if ($urandom_range(0, 2) != 0) begin
                bus.cdb_alu_tag   = TW'($urandom_range(0, 7));
                bus.cdb_alu_value = $urandom;
            end
            if ($urandom_range(0, 2) != 0) begin
                bus.cdb_lsb_tag   = TW'($urandom_range(0, 7));
                bus.cdb_lsb_value = $urandom;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
